double_to_sig16b: RTL and testbench
===================================

# double_to_sig16b

Output-side conversion stage of the echo-cancellation chain. It accepts one IEEE-754 double-precision sample per request (the cancelled residual, on the same integer scale that `sig16b_to_double` produces). It returns a signed 16-bit sample, rounded half away from zero and saturated to the 16-bit range, for the output/DAC path. The block is the mirror of `sig16b_to_double` and uses the same enable-pulse / ready-level handshake, so the per-sample sequencer drives it identically. Conversion is iterative, one mantissa bit per clock, so latency depends on the exponent.

## Interface
- No parameters.
- `clk_operation`  input  1  operation clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset. Asserted (0) forces the reset state immediately.
- `enable`  input  1  start request; sampled only in IDLE; one-cycle pulse expected.
- `double`  input  64  IEEE-754 double operand; captured on the accepting edge only.
- `sig16b`  output  16  two's-complement result; holds until the next result is written.
- `ready`  output  1  high when `sig16b` holds a valid result; low while a conversion is in progress.
- `overflow`  output  1  set with the result when saturation occurred or the input was NaN/Inf.

## Operation
- Fields: s = double[63], E = double[62:52], F = double[51:0]. Working mantissa M = {1, F} is 53 bits. Shift count k = 1075 − E.
- States: IDLE, SHIFT, ROUND.
- Reset (rst = 0): state IDLE, `sig16b` = 16'h0000, `ready` = 0, `overflow` = 0, k = 0, guard bit g = 0.
- IDLE, `enable` = 1: clear `ready`, capture s/E/F, then classify:
  - E == 2047 and F != 0 (NaN): result 0, `overflow` = 1, go to ROUND-bypass (see Timing).
  - E == 2047 and F == 0 (Inf), or E ≥ 1039, or (E == 1038 and not (s = 1 and F == 0)): saturate. Result 16'h7FFF if s = 0, 16'h8000 if s = 1; `overflow` = 1.
  - E == 1038, s = 1, F == 0 (exactly −32768.0): result 16'h8000, `overflow` = 0.
  - E < 1022 (|x| < 0.5, including zero and subnormals): result 16'h0000, `overflow` = 0.
  - Otherwise (1022 ≤ E ≤ 1037): load M, load k (range 38..53), set g = 0, go to SHIFT.
- SHIFT: on each edge, g ← M[0], M ← M >> 1, k ← k − 1. When k reaches 0, go to ROUND.
- ROUND: compute mag = M[15:0] + g (17-bit add).
  - s = 0 and mag > 32767: output 16'h7FFF, `overflow` = 1.
  - s = 1 and mag > 32768: cannot occur given the E range; if it does, treat as saturation to 16'h8000 with `overflow` = 1.
  - Otherwise: output +mag or −mag (two's complement), `overflow` = 0.
  - Then set `ready` = 1 and return to IDLE.
- `enable` while in SHIFT or ROUND is ignored; the operand is not captured and not queued.
- `ready` stays high in IDLE until the edge that accepts the next `enable`.
- `sig16b` and `overflow` change only when a result is written.

## Timing
- `enable` accepted at edge N. Normal path: k shifts occur at edges N+1..N+k; the result and `ready` = 1 are registered at edge N+k+1. Latency k+1 clocks, range 39..54.
- Special-value path (NaN/Inf/saturate/−32768/tiny): the result and `ready` = 1 are registered at edge N+1. Latency 1 clock.
- `ready` is 0 from edge N until the result edge, and is never high in the same cycle as stale data.
- Back-to-back: `enable` may be reasserted on the cycle after `ready` rises. It is accepted at that edge, and `ready` falls at that same edge.
- Reset mid-conversion aborts immediately with no result written. After release, the next `enable` starts cleanly.

## Test plan
- 0x3FF0000000000000 (1.0), `enable` pulse at edge N -> `ready` at N+53, `sig16b` = 16'h0001, `overflow` = 0; `ready` is 0 during N+1..N+52.
- 0x4004000000000000 (2.5) -> 16'h0003 at N+52. 0xBFF8000000000000 (−1.5) -> 16'hFFFE at N+53. Both `overflow` = 0.
- 0x40E3880000000000 (40000.0) -> 16'h7FFF, `overflow` = 1 at N+1. 0xC0E0000000000000 (−32768.0) -> 16'h8000, `overflow` = 0 at N+1.
- 0x3FD0000000000000 (0.25) -> 16'h0000 at N+1. 0x7FF8000000000000 (NaN) -> 16'h0000 with `overflow` = 1. 0xFFF0000000000000 (−Inf) -> 16'h8000 with `overflow` = 1.
- Start 1.0, pulse `enable` again with 40000.0 at N+10 -> second request ignored; result 16'h0001 at N+53. Then issue 40000.0 after `ready` -> 16'h7FFF one clock later.
- Start 1.0, assert `rst` = 0 at N+20 -> `sig16b` = 0, `ready` = 0, `overflow` = 0 immediately (asynchronous). Release, then convert 2.5 -> 16'h0003 with nominal latency.

Source files
------------

// File: rtl/double_to_sig16b.sv
// double_to_sig16b: converts an IEEE-754 double, which is already on the 16-bit
// integer scale, to a signed 16-bit sample. The result is rounded half away from
// zero and saturated to the 16-bit range.
// Special values (NaN, Inf, out-of-range, exact -32768, |x| < 0.5) resolve in
// one clock. Normal values shift the mantissa right one bit per clock until the
// integer part is aligned. The last bit shifted out is kept as the rounding bit.
module double_to_sig16b (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] double,
    output logic [15:0] sig16b,
    output logic        ready,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t      state;
    logic        sign;
    logic [52:0] mant;
    logic [5:0]  k;
    logic        g;
    logic        bypass;
    logic [15:0] spec_result;
    logic        spec_ovf;

    logic        in_s;
    logic [10:0] in_e;
    logic [51:0] in_f;
    logic        cls_special;
    logic [15:0] cls_result;
    logic        cls_ovf;
    logic [5:0]  k_load;
    logic [16:0] mag;

    assign in_s = double[63];
    assign in_e = double[62:52];
    assign in_f = double[51:0];

    // Shift count 1075 - E, only used for E in 1022..1037, so it lies in 38..53.
    // That range fits in 6 bits, so the low exponent bits are enough (1075 mod 64 = 51).
    assign k_load = 6'd51 - in_e[5:0];

    // Rounded magnitude: the aligned integer part plus the last bit shifted out.
    assign mag = {1'b0, mant[15:0]} + {16'd0, g};

    // Classify the incoming operand. Each special value gets its final result here.
    always_comb begin
        cls_special = 1'b1;
        cls_result  = 16'h0000;
        cls_ovf     = 1'b0;
        if (in_e == 11'd2047 && in_f != 52'd0) begin
            cls_result = 16'h0000;
            cls_ovf    = 1'b1;
        end else if (in_e == 11'd2047 || in_e >= 11'd1039 ||
                     (in_e == 11'd1038 && !(in_s && in_f == 52'd0))) begin
            cls_result = in_s ? 16'h8000 : 16'h7FFF;
            cls_ovf    = 1'b1;
        end else if (in_e == 11'd1038) begin
            cls_result = 16'h8000;
            cls_ovf    = 1'b0;
        end else if (in_e < 11'd1022) begin
            cls_result = 16'h0000;
            cls_ovf    = 1'b0;
        end else begin
            cls_special = 1'b0;
        end
    end

    // Control FSM: accepts a request, shifts the mantissa, then writes the rounded result.
    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sig16b      <= 16'h0000;
            ready       <= 1'b0;
            overflow    <= 1'b0;
            k           <= 6'd0;
            g           <= 1'b0;
            sign        <= 1'b0;
            mant        <= 53'd0;
            bypass      <= 1'b0;
            spec_result <= 16'h0000;
            spec_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        ready <= 1'b0;
                        sign  <= in_s;
                        if (cls_special) begin
                            // The result is already known. ROUND publishes it on the next edge.
                            spec_result <= cls_result;
                            spec_ovf    <= cls_ovf;
                            bypass      <= 1'b1;
                            state       <= ROUND;
                        end else begin
                            mant   <= {1'b1, in_f};
                            k      <= k_load;
                            g      <= 1'b0;
                            bypass <= 1'b0;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    g    <= mant[0];
                    mant <= mant >> 1;
                    k    <= k - 6'd1;
                    if (k == 6'd1) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (bypass) begin
                        sig16b   <= spec_result;
                        overflow <= spec_ovf;
                    end else if (!sign && mag > 17'd32767) begin
                        sig16b   <= 16'h7FFF;
                        overflow <= 1'b1;
                    end else if (sign && mag > 17'd32768) begin
                        sig16b   <= 16'h8000;
                        overflow <= 1'b1;
                    end else begin
                        sig16b   <= sign ? (~mag[15:0]) + 16'd1 : mag[15:0];
                        overflow <= 1'b0;
                    end
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_double_to_sig16b.sv
// Testbench for double_to_sig16b. It uses directed vectors with hand-computed
// results and latencies. A real-arithmetic reference model runs next to the DUT,
// and its outputs are compared with the DUT on every clock.
module tb_double_to_sig16b;

    logic        clk_operation = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] double = 64'd0;
    logic [15:0] sig16b;
    logic        ready;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    int nprint = 0;
    logic cmp_on = 1'b0;

    always #5 clk_operation = ~clk_operation;

    double_to_sig16b dut (
        .clk_operation (clk_operation),
        .rst           (rst),
        .enable        (enable),
        .double        (double),
        .sig16b        (sig16b),
        .ready         (ready),
        .overflow      (overflow)
    );

    // Reference result {overflow, sig16b}, computed from the numeric value.
    function automatic logic [16:0] model_result(input logic [63:0] d);
        real x, a, f;
        int mi;
        logic [15:0] r;
        x = $bitstoreal(d);
        if (d[62:52] == 11'h7FF && d[51:0] != 52'd0) return {1'b1, 16'h0000};
        if (x >= 32767.5) return {1'b1, 16'h7FFF};
        if (x < -32768.0) return {1'b1, 16'h8000};
        a = (x < 0.0) ? -x : x;
        f = $floor(a);
        mi = int'(f) + (((a - f) >= 0.5) ? 1 : 0);
        r = 16'(mi);
        if (x < 0.0) r = -r;
        return {1'b0, r};
    endfunction

    // Reference latency: 1076 - E clocks for the iterative range, otherwise 1.
    function automatic int model_latency(input logic [63:0] d);
        int e;
        e = int'(d[62:52]);
        if (e >= 1022 && e <= 1037) return 1076 - e;
        return 1;
    endfunction

    // Model state
    logic [15:0] m_sig, p_sig;
    logic        m_ovf, p_ovf, m_ready, m_busy;
    int          m_left;

    // Reference model: one request in flight, and enables are ignored while busy.
    always @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            m_sig   <= 16'h0000;
            m_ovf   <= 1'b0;
            m_ready <= 1'b0;
            m_busy  <= 1'b0;
            m_left  <= 0;
            p_sig   <= 16'h0000;
            p_ovf   <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_sig   <= p_sig;
                m_ovf   <= p_ovf;
            end
        end else if (enable) begin
            {p_ovf, p_sig} <= model_result(double);
            m_left  <= model_latency(double);
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
        end
    end

    // Per-cycle compare of the DUT outputs against the model.
    always @(negedge clk_operation) begin
        if (rst && cmp_on) begin
            checks++;
            if (ready !== m_ready || sig16b !== m_sig || overflow !== m_ovf) begin
                failures++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL cycle_cmp t=%0t: got ready=%b sig=%h ovf=%b, want ready=%b sig=%h ovf=%b",
                             $time, ready, sig16b, overflow, m_ready, m_sig, m_ovf);
                end
            end
        end
    end

    // Wait for ready, counting edges since acceptance. Called at a negedge.
    task automatic wait_ready(input int start, output int cnt);
        cnt = start;
        while (!ready && cnt < 80) begin
            @(posedge clk_operation);
            cnt++;
            @(negedge clk_operation);
        end
    endtask

    task automatic check_txn(input string name, input int cnt, input logic [15:0] es,
                             input logic eo, input int el);
        checks++;
        if (cnt != el || sig16b !== es || overflow !== eo || ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: got sig=%h ovf=%b lat=%0d ready=%b, want sig=%h ovf=%b lat=%0d ready=1",
                     name, sig16b, overflow, cnt, ready, es, eo, el);
        end else begin
            $display("txn %s: sig=%h ovf=%b lat=%0d ok", name, sig16b, overflow, cnt);
        end
    endtask

    // One request. It is called at a negedge, so the request is accepted on the next edge.
    task automatic convert(input string name, input logic [63:0] d, input logic [15:0] es,
                           input logic eo, input int el);
        int cnt;
        enable = 1'b1;
        double = d;
        @(posedge clk_operation);
        @(negedge clk_operation);
        enable = 1'b0;
        wait_ready(0, cnt);
        check_txn(name, cnt, es, eo, el);
    endtask

    initial begin
        int cnt;
        // Reset state
        repeat (3) @(negedge clk_operation);
        checks++;
        if (sig16b !== 16'h0000 || ready !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got sig=%h ready=%b ovf=%b, want 0000 0 0", sig16b, ready, overflow);
        end
        rst = 1'b1;
        cmp_on = 1'b1;
        @(negedge clk_operation);

        // Directed vectors, back-to-back where the previous one just completed
        convert("one",      64'h3FF0000000000000, 16'h0001, 1'b0, 53);
        convert("two_p5",   64'h4004000000000000, 16'h0003, 1'b0, 52);
        convert("neg1_p5",  64'hBFF8000000000000, 16'hFFFE, 1'b0, 53);
        convert("p40000",   64'h40E3880000000000, 16'h7FFF, 1'b1, 1);
        convert("neg32768", 64'hC0E0000000000000, 16'h8000, 1'b0, 1);
        convert("q25",      64'h3FD0000000000000, 16'h0000, 1'b0, 1);
        convert("nan",      64'h7FF8000000000000, 16'h0000, 1'b1, 1);
        convert("neg_inf",  64'hFFF0000000000000, 16'h8000, 1'b1, 1);
        convert("half",     64'h3FE0000000000000, 16'h0001, 1'b0, 54);
        convert("p32767",   64'h40DFFFC000000000, 16'h7FFF, 1'b0, 39);
        convert("p32767p5", 64'h40DFFFE000000000, 16'h7FFF, 1'b1, 39);
        convert("n32767p5", 64'hC0DFFFE000000000, 16'h8000, 1'b0, 39);
        convert("zero",     64'h0000000000000000, 16'h0000, 1'b0, 1);

        // A second enable during a conversion is ignored
        enable = 1'b1;
        double = 64'h3FF0000000000000;
        @(posedge clk_operation);
        @(negedge clk_operation);
        enable = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk_operation);
            @(negedge clk_operation);
        end
        enable = 1'b1;
        double = 64'h40E3880000000000;
        @(posedge clk_operation);
        @(negedge clk_operation);
        enable = 1'b0;
        wait_ready(10, cnt);
        check_txn("ignore_busy", cnt, 16'h0001, 1'b0, 53);
        convert("after_ign", 64'h40E3880000000000, 16'h7FFF, 1'b1, 1);

        // Asynchronous reset in the middle of a conversion
        enable = 1'b1;
        double = 64'h3FF0000000000000;
        @(posedge clk_operation);
        @(negedge clk_operation);
        enable = 1'b0;
        repeat (20) @(posedge clk_operation);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (sig16b !== 16'h0000 || ready !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got sig=%h ready=%b ovf=%b, want 0000 0 0", sig16b, ready, overflow);
        end else begin
            $display("txn async_reset: outputs cleared ok");
        end
        @(negedge clk_operation);
        @(negedge clk_operation);
        rst = 1'b1;
        @(negedge clk_operation);
        convert("post_reset", 64'h4004000000000000, 16'h0003, 1'b0, 52);

        repeat (2) @(negedge clk_operation);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
